// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: shared types for the up/down counter and its priority decode.
// Pure declarations; no state, no latency, no flow control.
package updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_STEP
    } op_e;

    // clear beats load beats enable; anything else holds
    function automatic op_e decode_op(input logic clear, input logic load, input logic enable);
        if (clear) begin
            return OP_CLEAR;
        end else if (load) begin
            return OP_LOAD;
        end else if (enable) begin
            return OP_STEP;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// updown_counter_next: combinational next count and boundary-event for one decoded operation.
// Zero latency; no flow control (pure function of its inputs).
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  op_e              op_i,
    input  dir_e             dir_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    always_comb begin
        count_o = count_i;
        wrap_o  = 1'b0;
        case (op_i)
            OP_CLEAR: begin
                count_o = '0;
            end
            OP_LOAD: begin
                count_o = (load_data_i > MAX_W) ? MAX_W : load_data_i;
            end
            OP_STEP: begin
                if (dir_i == DIR_UP) begin
                    if (count_i == MAX_W) begin
                        wrap_o = 1'b1;
                        if (SATURATE == 0) begin
                            count_o = '0;
                        end
                    end else begin
                        count_o = count_i + ONE_W;
                    end
                end else begin
                    // saturating at a boundary still flags the event every cycle
                    if (count_i == '0) begin
                        wrap_o = 1'b1;
                        if (SATURATE == 0) begin
                            count_o = MAX_W;
                        end
                    end else begin
                        count_o = count_i - ONE_W;
                    end
                end
            end
            default: begin
                count_o = count_i;
            end
        endcase
    end

endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: modulo-N up/down counter, wrap or saturate; sticky ovf under UPDOWN_COUNTER_OVF_STICKY_EN.
// Latency: count/wrap one edge after controls are sampled, tc combinational; no backpressure.
module updown_counter_n
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    input  logic             up_dn,
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

    op_e              op;
    dir_e             dir;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    assign dir = dir_e'(up_dn);
    assign op  = decode_op(clear, load, enable);

    updown_counter_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .op_i        (op),
        .dir_i       (dir),
        .count_i     (count_q),
        .load_data_i (load_data),
        .count_o     (count_d),
        .wrap_o      (wrap_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = ((dir == DIR_UP) && (count_q == MAX_W)) || ((dir == DIR_DOWN) && (count_q == '0));

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    logic ovf_q;
    logic ovf_d;

    // a new boundary event outranks a same-edge clear request
    always_comb begin
        ovf_d = ovf_q;
        if (wrap_d) begin
            ovf_d = 1'b1;
        end else if (ovf_clr || clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench: three counters (mod-10 wrap, mod-10 saturate, default mod-16) on shared stimulus.
module tb_updown_counter_n;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       load;
    logic [3:0] load_data;
    logic       enable;
    logic       up_dn;
    logic       ovf_clr;

    logic [3:0] w_count, s_count, d_count;
    logic       w_tc, s_tc, d_tc;
    logic       w_wrap, s_wrap, d_wrap;
    logic       w_ovf, s_ovf, d_ovf;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_data(load_data),
        .enable(enable), .up_dn(up_dn),
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(w_ovf),
`endif
        .count(w_count), .tc(w_tc), .wrap(w_wrap)
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_data(load_data),
        .enable(enable), .up_dn(up_dn),
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(s_ovf),
`endif
        .count(s_count), .tc(s_tc), .wrap(s_wrap)
    );

    updown_counter_n #(.WIDTH(4)) u_def (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_data(load_data),
        .enable(enable), .up_dn(up_dn),
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        .ovf_clr(ovf_clr), .ovf(d_ovf),
`endif
        .count(d_count), .tc(d_tc), .wrap(d_wrap)
    );

`ifndef UPDOWN_COUNTER_OVF_STICKY_EN
    assign w_ovf = 1'b0;
    assign s_ovf = 1'b0;
    assign d_ovf = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // sample and re-drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] val);
        load      = 1'b1;
        load_data = val;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        load      = 1'b0;
        load_data = 4'd0;
        enable    = 1'b0;
        up_dn     = 1'b0;
        ovf_clr   = 1'b0;

        // ---- 1: reset state, then asynchronous reset mid-count
        #12;
        check("rst_count", 32'(w_count), 0);
        check("rst_wrap", 32'(w_wrap), 0);
        check("rst_tc_down", 32'(w_tc), 1);
        check("rst_ovf", 32'(w_ovf), 0);
        tick();
        reset_n = 1'b1;
        do_load(4'd3);
        enable = 1'b1;
        up_dn  = 1'b1;
        tick();
        tick();
        check("pre_rst_count", 32'(w_count), 5);
        enable = 1'b0;
        up_dn  = 1'b0;
        load   = 1'b1;
        load_data = 4'd7;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_count", 32'(w_count), 0);
        check("async_rst_wrap", 32'(w_wrap), 0);
        check("async_rst_tc", 32'(w_tc), 1);
        tick();
        check("rst_holds_load", 32'(w_count), 0);
        load    = 1'b0;
        reset_n = 1'b1;

        // ---- 2: wrap mode, 12 cycles up from 0, then down from 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", 32'(w_count), 0);
        enable = 1'b1;
        up_dn  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("up_count_%0d", i), 32'(w_count), 32'(i % 10));
            check($sformatf("up_wrap_%0d", i), 32'(w_wrap), (i == 10) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        enable = 1'b1;
        up_dn  = 1'b0;
        tick();
        check("dn_wrap_count", 32'(w_count), 9);
        check("dn_wrap_flag", 32'(w_wrap), 1);
        enable = 1'b0;
        tick();
        check("dn_hold_count", 32'(w_count), 9);
        check("dn_wrap_pulse_end", 32'(w_wrap), 0);

        // ---- 3: saturate mode up from 8
        do_load(4'd8);
        check("sat_load8", 32'(s_count), 8);
        enable = 1'b1;
        up_dn  = 1'b1;
        check("sat_tc_at8", 32'(s_tc), 0);
        tick();
        check("sat_c1", 32'(s_count), 9);
        check("sat_w1", 32'(s_wrap), 0);
        check("sat_tc1", 32'(s_tc), 1);
        tick();
        check("sat_c2", 32'(s_count), 9);
        check("sat_w2", 32'(s_wrap), 1);
        check("sat_tc2", 32'(s_tc), 1);
        tick();
        check("sat_c3", 32'(s_count), 9);
        check("sat_w3", 32'(s_wrap), 1);
        check("sat_tc3", 32'(s_tc), 1);
        enable = 1'b0;

        // ---- 4: priority and clamp
        clear     = 1'b1;
        load      = 1'b1;
        load_data = 4'd3;
        tick();
        clear     = 1'b0;
        load      = 1'b0;
        check("clr_over_load", 32'(w_count), 0);
        do_load(4'd14);
        check("load_clamp", 32'(w_count), 9);
        check("load_noclamp_def", 32'(d_count), 14);
        enable = 1'b1;
        up_dn  = 1'b1;
        do_load(4'd6);
        check("load_over_step", 32'(w_count), 6);
        check("load_no_wrap", 32'(w_wrap), 0);
        enable = 1'b0;

        // ---- 5: direction toggling, default modulus, combinational tc
        do_load(4'd4);
        enable = 1'b1;
        up_dn  = 1'b1;
        tick();
        check("dir_c1", 32'(w_count), 5);
        up_dn = 1'b0;
        tick();
        check("dir_c2", 32'(w_count), 4);
        up_dn = 1'b1;
        tick();
        check("dir_c3", 32'(w_count), 5);
        up_dn = 1'b0;
        tick();
        check("dir_c4", 32'(w_count), 4);
        enable = 1'b0;
        up_dn  = 1'b1;
        do_load(4'd15);
        check("def_load15", 32'(d_count), 15);
        check("def_tc15", 32'(d_tc), 1);
        enable = 1'b1;
        tick();
        check("def_wrap_count", 32'(d_count), 0);
        check("def_wrap_flag", 32'(d_wrap), 1);
        check("mod10_wrap_count", 32'(w_count), 0);
        enable = 1'b0;
        #1;
        check("tc_up_at0", 32'(w_tc), 0);
        up_dn = 1'b0;
        #1;
        check("tc_down_at0", 32'(w_tc), 1);
        tick();

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        // ---- 6: sticky overflow
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovf_cleared", 32'(w_ovf), 0);
        do_load(4'd9);
        check("ovf_still0", 32'(w_ovf), 0);
        enable = 1'b1;
        up_dn  = 1'b1;
        tick();
        check("ovf_set", 32'(w_ovf), 1);
        enable = 1'b0;
        tick();
        tick();
        check("ovf_persist", 32'(w_ovf), 1);
        do_load(4'd9);
        enable  = 1'b1;
        ovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", 32'(w_ovf), 1);
        check("ovf_set_wins_wrap", 32'(w_wrap), 1);
        enable = 1'b0;
        tick();
        check("ovf_clr_alone", 32'(w_ovf), 0);
        ovf_clr = 1'b0;
        tick();
        check("ovf_stays_clr", 32'(w_ovf), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
